alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters (e.g. main datapath and an address/branch-compare helper).
- Per-requester valid/ready request channel; per-requester valid/ready response channel.
- Drives the ALU operand and opcode lines from registered operands, captures result and zero flag, and returns them to the granted requester.
- Round-robin arbitration; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand and result width; must match the shared ALU.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_s  input  3  requester 0 ALU opcode: 000 add, 001 sub, 010 slt, 011 srl, 100 sll, 101 or, 110 and, 111 xor
- resp0_valid  output  1  result for requester 0 available
- resp0_ready  input  1  requester 0 consumes result
- resp0_result  output  WIDTH  captured ALU result
- resp0_zero  output  1  captured ALU zero flag
- req1_*, resp1_*  same as requester 0, for requester 1
- alu_a, alu_b  output  WIDTH  to shared ALU
- alu_s  output  3  to shared ALU
- alu_result  input  WIDTH  from shared ALU, combinational
- alu_zero  input  1  from shared ALU
- busy  output  1  high in EXEC or RESP

Behaviour:
- States: IDLE, EXEC, RESP. Reset value is IDLE.
- Reset (rst=1 at clk edge) sets:
  - state=IDLE, last_grant=1, so requester 0 wins the first contention.
  - All operand, result and zero registers cleared to 0.
  - resp*_valid=0 and busy=0.
  - Applies mid-operation: any in-flight operation and any unconsumed response are dropped.
- IDLE arbitration (combinational from registered state):
  - If only one reqN_valid is high, grant N.
  - If both are high, grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) && grant==N. Never both high. Ready does not depend on the requester's own ready inputs.
- Accept (reqN_valid && reqN_ready):
  - Latch a, b, s into operand registers.
  - Record owner=N and set last_grant=N.
  - Go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_s driven from operand registers (they are always driven from these registers; values outside EXEC are don't-care but stable).
  - At the clock edge, capture alu_result and alu_zero into the result registers. Go to RESP.
- RESP:
  - resp<owner>_valid=1; the other resp valid stays 0.
  - result and zero are held stable until the handshake.
  - On resp<owner>_ready, go to IDLE.
- Latency:
  - Accept at edge T: EXEC during cycle T+1, resp_valid visible after edge T+1 (second cycle after accept).
  - Minimum issue interval is 3 cycles per operation.
- New requests are never accepted in EXEC or RESP. reqN_ready=0 there, and pending valids must wait.
- A requester dropping valid before being granted is legal; nothing is recorded.
- resp*_result and resp*_zero outputs come straight from the registers for both ports; only valid is owner-qualified.
- Width: operands pass unmodified. The ALU's own shift and slt semantics apply; this block performs no arithmetic.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins when both are valid; last_grant is still updated but ignored.
- Undefined: round-robin as specified above.

Test Plan:
- Single op: req0 a=5, b=3, s=001 → req0_ready same cycle in IDLE; resp0_valid 2 cycles later with result=2, zero=0; resp1_valid stays 0.
- Zero flag: req1 a=7, b=7, s=111 → resp1_result=0, resp1_zero=1; held while resp1_ready=0 for 4 cycles, then cleared after resp1_ready=1.
- Contention after reset: both valid, req0 add 1+2, req1 or 8|1 → req0 served first (result 3), then req1 (result 9). Both held continuously: grants alternate 0,1,0,1 over 4 ops. With ALU_ARB_FIXED_PRIO_EN: 0,0,0,0.
- Blocking: req1 valid asserted during req0 EXEC/RESP → req1_ready=0 until IDLE; req1 accepted on the first IDLE cycle.
- Reset mid-op: assert rst during RESP with resp0_valid=1 → next cycle resp0_valid=0, busy=0, state IDLE; next contention grants requester 0.
- Shift passthrough: req0 a=0x80000000, b=4, s=011 → resp0_result=0x08000000; alu_a/alu_b/alu_s match the latched values during EXEC.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two valid/ready requesters (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_s,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_s,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d, owner_q, owner_d, zero_q, zero_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       s_q, s_d;
  logic             g1, acc0, acc1;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign g1 = req1_valid && !req0_valid;
`else
  assign g1 = req1_valid && (!req0_valid || !last_q);
`endif
  assign req0_ready   = (state_q == IDLE) && req0_valid && !g1;
  assign req1_ready   = (state_q == IDLE) && g1;
  assign acc0         = req0_valid && req0_ready;
  assign acc1         = req1_valid && req1_ready;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_s        = s_q;
  assign resp0_valid  = (state_q == RESP) && !owner_q;
  assign resp1_valid  = (state_q == RESP) && owner_q;
  assign resp0_result = res_q;
  assign resp1_result = res_q;
  assign resp0_zero   = zero_q;
  assign resp1_zero   = zero_q;
  assign busy         = state_q != IDLE;
  // next state: latch the granted request, capture the ALU output, wait for the owner to consume it
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    res_d   = res_q;
    zero_d  = zero_q;
    if (state_q == IDLE && (acc0 || acc1)) begin
      state_d = EXEC;
      owner_d = acc1;
      last_d  = acc1;
      a_d     = acc1 ? req1_a : req0_a;
      b_d     = acc1 ? req1_b : req0_b;
      s_d     = acc1 ? req1_s : req0_s;
    end else if (state_q == EXEC) begin
      state_d = RESP;
      res_d   = alu_result;
      zero_d  = alu_zero;
    end else if (state_q == RESP && (owner_q ? resp1_ready : resp0_ready)) begin
      state_d = IDLE;
    end
  end
  // state registers; last_grant resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed plus randomized checks of alu_share_arbiter against a transaction-level model
module tb_alu_share_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0_valid = 0, req1_valid = 0, resp0_ready = 0, resp1_ready = 0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, resp1_zero, alu_zero, busy;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0]  req0_s = 0, req1_s = 0, alu_s;
  logic [31:0] resp0_result, resp1_result, alu_a, alu_b, alu_result;
  int          checks = 0, errors = 0;
  bit          last_g = 1;
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return a >> b[4:0];
      3'd4: return a << b[4:0];
      3'd5: return a | b;
      3'd6: return a & b;
      default: return a ^ b;
    endcase
  endfunction
  assign alu_result = alu_ref(alu_a, alu_b, alu_s);
  assign alu_zero   = alu_result == 32'd0;
  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] s0,
                    input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] s1, input int hold, output int g);
    logic [31:0] ea, eb, er;
    logic [2:0]  es;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_s = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_s = s1;
    #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    g = !v0 && !v1 ? -1 : (v0 ? 0 : 1);
`else
    g = !v0 && !v1 ? -1 : (v0 && v1 ? (last_g ? 0 : 1) : (v0 ? 0 : 1));
`endif
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    if (g < 0) begin
      step();
      chk("idle_busy", {31'd0, busy}, 32'd0);
      return;
    end
    ea = g ? a1 : a0; eb = g ? b1 : b0; es = g ? s1 : s0;
    er = alu_ref(ea, eb, es);
    last_g = g[0];
    step();
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_s", {29'd0, alu_s}, {29'd0, es});
    chk("exec_blocked", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("exec_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    step();
    for (int i = 0; i <= hold; i++) begin
      chk("resp_valid", {30'd0, resp1_valid, resp0_valid}, g ? 32'd2 : 32'd1);
      chk("resp_result", g ? resp1_result : resp0_result, er);
      chk("resp_zero", {31'd0, g ? resp1_zero : resp0_zero}, {31'd0, er == 32'd0});
      chk("resp_blocked", {30'd0, req1_ready, req0_ready}, 32'd0);
      if (i == hold) begin
        if (g) resp1_ready = 1; else resp0_ready = 1;
      end
      step();
    end
    resp0_ready = 0; resp1_ready = 0;
    chk("done_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask
  initial begin
    int g;
    step(); step();
    rst = 0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_result", resp0_result, 32'd0);
    op(1, 0, 32'd5, 32'd3, 3'd1, 0, 0, 0, 0, g);
    chk("single_grant", g, 0);
    op(0, 1, 0, 0, 0, 32'd7, 32'd7, 3'd7, 4, g);
    chk("zero_grant", g, 1);
    rst = 1; step(); rst = 0; last_g = 1;
    for (int k = 0; k < 4; k++) begin
      op(1, 1, 32'd1, 32'd2, 3'd0, 32'd8, 32'd1, 3'd5, 0, g);
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("contend_grant", g, 0);
`else
      chk("contend_grant", g, k % 2);
`endif
    end
    op(1, 0, 32'h80000000, 32'd4, 3'd3, 0, 0, 0, 1, g);
    op(1, 0, 32'd9, 32'd4, 3'd0, 0, 0, 0, 0, g);
    req0_valid = 1; req1_valid = 0; #1;
    step(); req0_valid = 0; step();
    chk("mid_resp0", {31'd0, resp0_valid}, 32'd1);
    rst = 1; step(); rst = 0; last_g = 1;
    chk("mid_rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    op(1, 1, 32'd3, 32'd3, 3'd1, 32'd4, 32'd1, 3'd4, 0, g);
    chk("mid_rst_grant", g, 0);
    for (int k = 0; k < 60; k++)
      op($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, 3'($urandom),
         $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, 3'($urandom), $urandom_range(0, 3), g);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
